// File: rtl/branch_predictor.sv
// Branch predictor: direct-mapped BTB with per-entry 2-bit saturating
// direction counters and a stored jump bit. Lookup is purely combinational
// from registered state; updates commit on the clock edge with no bypass.
// Optional build macro BPRED_GSHARE_EN adds a global history register that
// is XORed into the counter index (BTB index/tag stay PC-based).
module branch_predictor #(
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] fetch_pc,
  output logic        pred_taken,
  output logic [63:0] pred_target,
  input  logic        upd_valid,
  input  logic [63:0] upd_pc,
  input  logic        upd_taken,
  input  logic [63:0] upd_target,
  input  logic        upd_is_jump,
  input  logic        upd_mispredict,
  output logic [31:0] mispredict_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);

  // Table state
  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [63:0]      r_target [ENTRIES];
  logic             r_jump   [ENTRIES];
  logic [1:0]       r_ctr    [ENTRIES];
  logic [31:0]      r_mp_cnt;

  // Lookup-side decode
  logic [IDX_W-1:0] w_f_idx;
  logic [IDX_W-1:0] w_f_cidx;
  logic [TAG_W-1:0] w_f_tag;
  logic             w_f_hit;

  // Update-side decode
  logic [IDX_W-1:0] w_u_idx;
  logic [IDX_W-1:0] w_u_cidx;
  logic [TAG_W-1:0] w_u_tag;
  logic             w_u_hit;
  logic [1:0]       w_u_ctr_cur;
  logic [1:0]       w_u_ctr_hit;
  logic [1:0]       w_u_ctr_alloc;

  assign w_f_idx = fetch_pc[IDX_W+1:2];
  assign w_f_tag = fetch_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign w_u_idx = upd_pc[IDX_W+1:2];
  assign w_u_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

`ifdef BPRED_GSHARE_EN
  logic [IDX_W-1:0] r_ghr;

  // Counter index hashes PC with the history as it stood before this update
  assign w_f_cidx = w_f_idx ^ r_ghr;
  assign w_u_cidx = w_u_idx ^ r_ghr;

  // Global history: shift in the outcome of every resolved conditional branch
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ghr <= '0;
    end else if (upd_valid && !upd_is_jump) begin
      r_ghr <= (r_ghr << 1) | IDX_W'(upd_taken);
    end
  end
`else
  assign w_f_cidx = w_f_idx;
  assign w_u_cidx = w_u_idx;
`endif

  // Combinational lookup; an update in flight this cycle is not visible yet
  always_comb begin
    w_f_hit     = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
    pred_taken  = w_f_hit && (r_jump[w_f_idx] || r_ctr[w_f_cidx][1]);
    pred_target = pred_taken ? r_target[w_f_idx] : (fetch_pc + 64'd4);
  end

  // Next counter value for an update that hits or allocates
  always_comb begin
    w_u_hit     = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
    w_u_ctr_cur = r_ctr[w_u_cidx];
    w_u_ctr_hit = w_u_ctr_cur;
    if (upd_is_jump) begin
      w_u_ctr_hit = 2'b11;
    end else if (upd_taken) begin
      if (w_u_ctr_cur != 2'b11) w_u_ctr_hit = w_u_ctr_cur + 2'd1;
    end else begin
      if (w_u_ctr_cur != 2'b00) w_u_ctr_hit = w_u_ctr_cur - 2'd1;
    end
    w_u_ctr_alloc = upd_is_jump ? 2'b11 : 2'b10;
  end

  // Table write: train on hit, allocate on taken miss; tags/targets are not reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < unsigned'(ENTRIES); i++) begin
        r_valid[i[IDX_W-1:0]] <= 1'b0;
        r_ctr[i[IDX_W-1:0]]   <= 2'b01;
      end
    end else if (upd_valid) begin
      if (w_u_hit) begin
        r_ctr[w_u_cidx] <= w_u_ctr_hit;
        if (upd_taken) begin
          r_target[w_u_idx] <= upd_target;
          r_jump[w_u_idx]   <= upd_is_jump;
        end
      end else if (upd_taken) begin
        r_valid[w_u_idx]  <= 1'b1;
        r_tag[w_u_idx]    <= w_u_tag;
        r_target[w_u_idx] <= upd_target;
        r_jump[w_u_idx]   <= upd_is_jump;
        r_ctr[w_u_cidx]   <= w_u_ctr_alloc;
      end
    end
  end

  // Saturating count of mispredictions reported by execute
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mp_cnt <= '0;
    end else if (upd_valid && upd_mispredict && (r_mp_cnt != '1)) begin
      r_mp_cnt <= r_mp_cnt + 32'd1;
    end
  end

  assign mispredict_cnt = r_mp_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor (default build, no global history).
module tb_branch_predictor;

  localparam int ENTRIES = 64;
  localparam int TAG_W   = 16;
  localparam int IDX_W   = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] fetch_pc = '0;
  logic        pred_taken;
  logic [63:0] pred_target;
  logic        upd_valid = 1'b0;
  logic [63:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [63:0] upd_target = '0;
  logic        upd_is_jump = 1'b0;
  logic        upd_mispredict = 1'b0;
  logic [31:0] mispredict_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_valid  [ENTRIES];
  logic [63:0] m_tag    [ENTRIES];
  logic [63:0] m_target [ENTRIES];
  bit          m_jump   [ENTRIES];
  int          m_ctr    [ENTRIES];
  longint      m_cnt;

  branch_predictor #(.ENTRIES(ENTRIES), .TAG_W(TAG_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_pc       (fetch_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_is_jump    (upd_is_jump),
    .upd_mispredict (upd_mispredict),
    .mispredict_cnt (mispredict_cnt)
  );

  always #5 clk = ~clk;

  function automatic int m_index(input logic [63:0] pc);
    return int'((pc >> 2) % 64'(ENTRIES));
  endfunction

  function automatic logic [63:0] m_tagof(input logic [63:0] pc);
    return (pc >> (IDX_W + 2)) % (64'd1 << TAG_W);
  endfunction

  function automatic void model_pred(input logic [63:0] pc, output bit t, output logic [63:0] tgt);
    int i;
    i = m_index(pc);
    t = m_valid[i] && (m_tag[i] == m_tagof(pc)) && (m_jump[i] || m_ctr[i] >= 2);
    tgt = t ? m_target[i] : pc + 64'd4;
  endfunction

  // Apply what the DUT saw at the edge just taken
  function automatic void model_update();
    int i;
    bit hit;
    if (!reset) begin
      for (int k = 0; k < ENTRIES; k++) begin
        m_valid[k] = 0;
        m_ctr[k] = 1;
      end
      m_cnt = 0;
      return;
    end
    if (!upd_valid) return;
    if (upd_mispredict && m_cnt < 64'hFFFF_FFFF) m_cnt++;
    i = m_index(upd_pc);
    hit = m_valid[i] && (m_tag[i] == m_tagof(upd_pc));
    if (hit) begin
      if (upd_is_jump)    m_ctr[i] = 3;
      else if (upd_taken) m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
      else                m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
      if (upd_taken) begin
        m_target[i] = upd_target;
        m_jump[i] = upd_is_jump;
      end
    end else if (upd_taken) begin
      m_valid[i] = 1;
      m_tag[i] = m_tagof(upd_pc);
      m_target[i] = upd_target;
      m_jump[i] = upd_is_jump;
      m_ctr[i] = upd_is_jump ? 3 : 2;
    end
  endfunction

  task automatic drive(input logic rst, input logic [63:0] fpc, input logic uv,
                       input logic [63:0] upc, input logic ut, input logic [63:0] utgt,
                       input logic uj, input logic um);
    @(negedge clk);
    reset = rst; fetch_pc = fpc; upd_valid = uv; upd_pc = upc;
    upd_taken = ut; upd_target = utgt; upd_is_jump = uj; upd_mispredict = um;
  endtask

  // Lookup only; update fields carry junk that must be ignored
  task automatic idle(input logic [63:0] fpc);
    drive(1'b1, fpc, 1'b0, {$urandom, $urandom}, 1'b1, {$urandom, $urandom}, 1'b0, 1'b1);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
  endtask

  task automatic test_reset();
    drive(1'b0, 64'h8000_0000, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    tick();
    idle(64'h8000_0000);
    #1;
    n_checks++;
    if (pred_taken !== 1'b0) begin
      n_fail++; $display("FAIL reset_taken: got %b want 0", pred_taken);
    end
    n_checks++;
    if (pred_target !== 64'h8000_0004) begin
      n_fail++; $display("FAIL reset_target: got %h want 0000000080000004", pred_target);
    end
    n_checks++;
    if (mispredict_cnt !== 32'd0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d want 0", mispredict_cnt);
    end
    tick();
  endtask

  task automatic test_alloc_and_counter();
    // allocate
    drive(1'b1, 64'h8000_0010, 1'b1, 64'h8000_0010, 1'b1, 64'h8000_0100, 1'b0, 1'b0);
    tick();
    idle(64'h8000_0010);
    #1;
    n_checks++;
    if (pred_taken !== 1'b1 || pred_target !== 64'h8000_0100) begin
      n_fail++; $display("FAIL alloc_pred: got %b/%h want 1/0000000080000100", pred_taken, pred_target);
    end
    tick();
    // two not-taken: 10 -> 01 -> 00
    for (int n = 0; n < 2; n++) begin
      drive(1'b1, 64'h8000_0010, 1'b1, 64'h8000_0010, 1'b0, 64'h0, 1'b0, 1'b0);
      tick();
    end
    idle(64'h8000_0010);
    #1;
    n_checks++;
    if (pred_taken !== 1'b0 || pred_target !== 64'h8000_0014) begin
      n_fail++; $display("FAIL ctr_dec: got %b/%h want 0/0000000080000014", pred_taken, pred_target);
    end
    tick();
    // third not-taken stays 00, then one taken only reaches 01
    drive(1'b1, 64'h8000_0010, 1'b1, 64'h8000_0010, 1'b0, 64'h0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 64'h8000_0010, 1'b1, 64'h8000_0010, 1'b1, 64'h8000_0100, 1'b0, 1'b0);
    tick();
    idle(64'h8000_0010);
    #1;
    n_checks++;
    if (pred_taken !== 1'b0) begin
      n_fail++; $display("FAIL ctr_sat_low: got %b want 0", pred_taken);
    end
    tick();
    // one more taken: 01 -> 10 predicts taken again
    drive(1'b1, 64'h8000_0010, 1'b1, 64'h8000_0010, 1'b1, 64'h8000_0100, 1'b0, 1'b0);
    tick();
    idle(64'h8000_0010);
    #1;
    n_checks++;
    if (pred_taken !== 1'b1) begin
      n_fail++; $display("FAIL ctr_inc: got %b want 1", pred_taken);
    end
    tick();
  endtask

  task automatic test_alias();
    drive(1'b1, 64'h0, 1'b1, 64'h8000_0010, 1'b1, 64'h8000_0100, 1'b0, 1'b0);
    tick();
    drive(1'b1, 64'h0, 1'b1, 64'h8001_0010, 1'b1, 64'h9000_0000, 1'b0, 1'b0);
    tick();
    idle(64'h8000_0010);
    #1;
    n_checks++;
    if (pred_taken !== 1'b0 || pred_target !== 64'h8000_0014) begin
      n_fail++; $display("FAIL alias_old: got %b/%h want 0/0000000080000014", pred_taken, pred_target);
    end
    tick();
    idle(64'h8001_0010);
    #1;
    n_checks++;
    if (pred_taken !== 1'b1 || pred_target !== 64'h9000_0000) begin
      n_fail++; $display("FAIL alias_new: got %b/%h want 1/0000000090000000", pred_taken, pred_target);
    end
    tick();
  endtask

  task automatic test_same_cycle();
    drive(1'b1, 64'h8000_0020, 1'b1, 64'h8000_0020, 1'b1, 64'h8000_0400, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (pred_taken !== 1'b0 || pred_target !== 64'h8000_0024) begin
      n_fail++; $display("FAIL same_cycle_old: got %b/%h want 0/0000000080000024", pred_taken, pred_target);
    end
    tick();
    idle(64'h8000_0020);
    #1;
    n_checks++;
    if (pred_taken !== 1'b1 || pred_target !== 64'h8000_0400) begin
      n_fail++; $display("FAIL same_cycle_new: got %b/%h want 1/0000000080000400", pred_taken, pred_target);
    end
    tick();
  endtask

  task automatic test_jump();
    // jump allocates with forced taken; a not-taken conditional on the entry
    // still predicts taken while the jump bit is set
    drive(1'b1, 64'h0, 1'b1, 64'h8000_0040, 1'b1, 64'h8000_1000, 1'b1, 1'b0);
    tick();
    drive(1'b1, 64'h0, 1'b1, 64'h8000_0040, 1'b0, 64'h0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 64'h0, 1'b1, 64'h8000_0040, 1'b0, 64'h0, 1'b0, 1'b0);
    tick();
    idle(64'h8000_0040);
    #1;
    n_checks++;
    if (pred_taken !== 1'b1 || pred_target !== 64'h8000_1000) begin
      n_fail++; $display("FAIL jump_bit: got %b/%h want 1/0000000080001000", pred_taken, pred_target);
    end
    tick();
    // top of address space wraps to 0 on fall-through
    idle(64'hFFFF_FFFF_FFFF_FFFC);
    #1;
    n_checks++;
    if (pred_taken !== 1'b0 || pred_target !== 64'h0) begin
      n_fail++; $display("FAIL wrap: got %b/%h want 0/0000000000000000", pred_taken, pred_target);
    end
    tick();
  endtask

  task automatic test_mispredict_cnt();
    drive(1'b0, 64'h0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    tick();
    for (int n = 0; n < 3; n++) begin
      drive(1'b1, 64'h0, 1'b1, 64'h8000_0080, 1'b0, 64'h0, 1'b0, 1'b1);
      tick();
    end
    drive(1'b1, 64'h0, 1'b0, 64'h8000_0080, 1'b1, 64'h0, 1'b0, 1'b1);
    tick();
    idle(64'h0);
    #1;
    n_checks++;
    if (mispredict_cnt !== 32'd3) begin
      n_fail++; $display("FAIL mp_cnt: got %0d want 3", mispredict_cnt);
    end
    tick();
    // reset wins over a simultaneous taken update
    drive(1'b0, 64'h0, 1'b1, 64'h8000_0030, 1'b1, 64'h8000_0700, 1'b0, 1'b1);
    tick();
    idle(64'h8000_0030);
    #1;
    n_checks++;
    if (pred_taken !== 1'b0 || pred_target !== 64'h8000_0034) begin
      n_fail++; $display("FAIL rst_override_pred: got %b/%h want 0/0000000080000034", pred_taken, pred_target);
    end
    n_checks++;
    if (mispredict_cnt !== 32'd0) begin
      n_fail++; $display("FAIL rst_override_cnt: got %0d want 0", mispredict_cnt);
    end
    tick();
  endtask

  task automatic test_random();
    bit          et;
    logic [63:0] etgt;
    logic [63:0] fpc, upc;
    for (int n = 0; n < 400; n++) begin
      fpc = 64'h8000_0000 | (64'($urandom_range(0, 7)) << 2) | (64'($urandom_range(0, 2)) << 8);
      upc = 64'h8000_0000 | (64'($urandom_range(0, 7)) << 2) | (64'($urandom_range(0, 2)) << 8);
      drive(1'b1, fpc, 1'($urandom_range(0, 1)), upc, 1'($urandom_range(0, 1)),
            {$urandom, $urandom}, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
      if (upd_is_jump) upd_taken = 1'b1;
      #1;
      model_pred(fetch_pc, et, etgt);
      n_checks++;
      if (pred_taken !== et || pred_target !== etgt) begin
        n_fail++; $display("FAIL rand_pred[%0d]: pc %h got %b/%h want %b/%h", n, fetch_pc, pred_taken, pred_target, et, etgt);
      end
      n_checks++;
      if (mispredict_cnt !== 32'(m_cnt)) begin
        n_fail++; $display("FAIL rand_cnt[%0d]: got %0d want %0d", n, mispredict_cnt, m_cnt);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_alloc_and_counter();
    test_alias();
    test_same_cycle();
    test_jump();
    test_mispredict_cnt();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL have parameter ENTRIES, default 64, giving the number of BTB/BHT entries (power of two, IDX_W = log2(ENTRIES)).
REQ-002 The block SHALL have parameter TAG_W, default 16, giving the BTB tag width.
REQ-003 The block SHALL use a single clock and a synchronous, active-low reset, with ports `clk` and `reset` named as elsewhere in the codebase.
REQ-004 The block SHALL provide port: clk  input  1  rising-edge clock.
REQ-005 The block SHALL provide port: reset  input  1  synchronous reset, active-low.
REQ-006 The block SHALL provide port: fetch_pc  input  64  PC being fetched.
REQ-007 The block SHALL provide port: pred_taken  output  1  predicted redirect for fetch_pc.
REQ-008 The block SHALL provide port: pred_target  output  64  predicted next PC.
REQ-009 The block SHALL provide port: upd_valid  input  1  execute-stage resolution of a branch or jump this cycle.
REQ-010 The block SHALL provide port: upd_pc  input  64  PC of the resolved instruction.
REQ-011 The block SHALL provide port: upd_taken  input  1  actual direction.
REQ-012 The block SHALL provide port: upd_target  input  64  actual target.
REQ-013 The block SHALL provide port: upd_is_jump  input  1  unconditional jump (JAL/JALR).
REQ-014 The block SHALL provide port: upd_mispredict  input  1  execute detected a wrong prediction.
REQ-015 The block SHALL provide port: mispredict_cnt  output  32  count of mispredictions.

Function
REQ-016 Index SHALL be pc[IDX_W+1:2]; tag SHALL be pc[IDX_W+TAG_W+1:IDX_W+2].
REQ-017 Each entry SHALL hold: valid, tag, 64-bit target, 2-bit saturating counter.
REQ-018 Lookup SHALL be combinational from registered state, with zero cycles of latency.
REQ-019 Hit SHALL be defined as valid && tag match.
REQ-020 pred_taken SHALL be hit && (entry is jump || ctr[1]); the per-entry jump bit is stored.
REQ-021 pred_target SHALL be the entry target when pred_taken, else fetch_pc+4 (64-bit wrap).
REQ-022 Updates SHALL be written at the posedge on which upd_valid=1; the new contents SHALL be visible to lookups from the next cycle onward.
REQ-023 A lookup in the same cycle as an update to the same index SHALL see the old contents; there SHALL be no bypass.
REQ-024 On update hit: ctr SHALL go +1 when taken and -1 when not taken, saturating at 2'b11 and 2'b00; a jump SHALL force 2'b11; target and jump bit SHALL be written when taken.
REQ-025 On update miss with upd_taken=1: the entry SHALL be replaced (valid=1, new tag/target/jump bit, ctr = 2'b11 if jump else 2'b10).
REQ-026 On update miss with upd_taken=0: no table change SHALL occur.
REQ-027 When upd_valid && upd_mispredict, mispredict_cnt SHALL increment by 1, saturating at 32'hFFFF_FFFF.
REQ-028 Update inputs SHALL be ignored when upd_valid=0.

Reset
REQ-029 When reset=0 at a posedge, all valid bits SHALL clear, all ctr SHALL become 2'b01, mispredict_cnt SHALL become 0, and the GHR SHALL become 0.
REQ-030 Reset SHALL override a simultaneous update.
REQ-031 After reset, pred_taken SHALL be 0 and pred_target SHALL be fetch_pc+4.
REQ-032 Tags and targets need not be reset.

Configuration
REQ-033 With BPRED_GSHARE_EN defined, an IDX_W-bit global history register SHALL shift left at each update with upd_valid && !upd_is_jump, inserting upd_taken at bit 0.
REQ-034 With BPRED_GSHARE_EN defined, the counter index SHALL be the PC index XOR the GHR (pre-shift value at update), while the BTB index/tag SHALL remain PC-based.
REQ-035 Without BPRED_GSHARE_EN, no GHR SHALL exist and the counter index SHALL equal the BTB index.

Verification
REQ-036 Reset, then fetch_pc=0x8000_0000 -> pred_taken=0, pred_target=0x8000_0004.
REQ-037 Update upd_pc=0x8000_0010, taken, target=0x8000_0100, is_jump=0; next cycle fetch_pc=0x8000_0010 -> pred_taken=1, pred_target=0x8000_0100 (ctr=10).
REQ-038 Same entry: two not-taken updates -> ctr 10→01→00, pred_taken=0; a third not-taken update -> ctr stays 00; a taken update -> 01, still pred_taken=0.
REQ-039 Alias: update 0x8000_0010 taken, then update 0x8001_0010 (same index, different tag) taken target 0x9000_0000 -> lookup 0x8000_0010 misses (pred_taken=0); lookup 0x8001_0010 -> 0x9000_0000.
REQ-040 Same-cycle update and lookup of 0x8000_0020 (previously empty) -> pred_taken=0 that cycle, 1 the next cycle.
REQ-041 Three upd_valid&&upd_mispredict pulses, then one pulse with upd_valid=0 -> mispredict_cnt=3; reset asserted alongside a taken update -> entry not allocated, cnt=0.
